elgamal_enc_seq: RTL and testbench

ELGAMAL_ENC_SEQ -- requirements
Module: elgamal_enc_seq

---
 rtl/elgamal_pkg.sv | 34 +++
 rtl/elgamal_enc_seq_op_watchdog.sv | 47 ++++
 rtl/elgamal_enc_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_elgamal_enc_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elgamal_pkg.sv
// ---------------------------------------------------------------------------
// elgamal_pkg
// Shared definitions for the sequential ElGamal encryption controller:
//   SIZE_DEF     default operand/result width in bits
//   TIMEOUT_DEF  default number of cycles a WAIT state may last
//   state_t      controller state encoding
//   is_wait()    true for the three result-waiting states
// ---------------------------------------------------------------------------
package elgamal_pkg;

  localparam int unsigned SIZE_DEF    = 32'd64;
  localparam int unsigned TIMEOUT_DEF = 32'd4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXP1_REQ  = 3'd1,
    ST_EXP1_WAIT = 3'd2,
    ST_EXP2_REQ  = 3'd3,
    ST_EXP2_WAIT = 3'd4,
    ST_MUL_REQ   = 3'd5,
    ST_MUL_WAIT  = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  function automatic logic is_wait(input state_t s);
    logic r;
    case (s)
      ST_EXP1_WAIT, ST_EXP2_WAIT, ST_MUL_WAIT: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elgamal_enc_seq_op_watchdog.sv
// ---------------------------------------------------------------------------
// op_watchdog
// Loadable down-counter that flags expiry when it has counted down to zero.
//   clk, rst     clock, asynchronous active-high reset (counter -> 0)
//   load_i       load load_val_i (has priority over counting)
//   load_val_i   value loaded on load_i
//   en_i         decrement by one per cycle while non-zero
//   expired_o    counter is zero
// ---------------------------------------------------------------------------
module op_watchdog #(
  parameter int unsigned CNT_W = 32'd13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise saturating decrement while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/elgamal_enc_seq.sv
// ---------------------------------------------------------------------------
// elgamal_enc_seq
// Sequential ElGamal encryption: c1 = g^k mod p, s = y^k mod p,
// c2 = m*s mod p, using one shared external mod_exp unit (used twice) and
// one external modular multiplier. All valid/ready outputs are registered.
//   clk, rst                      clock, asynchronous active-high reset
//   in_g/y/k/m/p, in_tvalid/ready request operands and handshake
//   exp_*                         mod_exp request (base/power/modulus) and result
//   mul_*                         modular multiplier request and result
//   c1_tdata, c2_tdata, out_err,
//   out_tvalid/out_tready         ciphertext result and handshake
//   busy                          controller not in IDLE
// ---------------------------------------------------------------------------
module elgamal_enc_seq
  import elgamal_pkg::*;
#(
  parameter int unsigned SIZE    = SIZE_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_g,
  input  logic [SIZE-1:0] in_y,
  input  logic [SIZE-1:0] in_k,
  input  logic [SIZE-1:0] in_m,
  input  logic [SIZE-1:0] in_p,
  input  logic            in_tvalid,
  output logic            in_tready,
  output logic [SIZE-1:0] exp_base_tdata,
  output logic [SIZE-1:0] exp_power_tdata,
  output logic [SIZE-1:0] exp_modulus_tdata,
  output logic            exp_in_tvalid,
  input  logic            exp_in_tready,
  input  logic [SIZE-1:0] exp_out_tdata,
  input  logic            exp_out_tvalid,
  output logic            exp_out_tready,
  output logic [SIZE-1:0] mul_a_tdata,
  output logic [SIZE-1:0] mul_b_tdata,
  output logic [SIZE-1:0] mul_mod_tdata,
  output logic            mul_in_tvalid,
  input  logic            mul_in_tready,
  input  logic [SIZE-1:0] mul_out_tdata,
  input  logic            mul_out_tvalid,
  output logic            mul_out_tready,
  output logic [SIZE-1:0] c1_tdata,
  output logic [SIZE-1:0] c2_tdata,
  output logic            out_err,
  output logic            out_tvalid,
  input  logic            out_tready,
  output logic            busy
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 32'd1);
  // Loaded with TIMEOUT-1 so expiry is seen in the TIMEOUT-th WAIT cycle
  // and DONE is entered exactly TIMEOUT cycles after WAIT entry.
  localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [SIZE-1:0]  ZERO    = {SIZE{1'b0}};
  localparam logic [SIZE-1:0]  TWO     = SIZE'(2'd2);

  state_t state_q, state_d;

  logic [SIZE-1:0] g_q, g_d, y_q, y_d, k_q, k_d, m_q, m_d, p_q, p_d;
  logic [SIZE-1:0] s_q, s_d, c1_q, c1_d, c2_q, c2_d;
  logic            err_q, err_d;

  logic in_tready_q, in_tready_d;
  logic busy_q, busy_d;
  logic exp_in_tvalid_q, exp_in_tvalid_d;
  logic exp_out_tready_q, exp_out_tready_d;
  logic mul_in_tvalid_q, mul_in_tvalid_d;
  logic mul_out_tready_q, mul_out_tready_d;
  logic out_tvalid_q, out_tvalid_d;

  logic in_hs_s, exp_hs_s, exp_res_s, mul_hs_s, mul_res_s, out_hs_s;
  logic p_small_s, p_small_d;
  logic wd_load_s, wd_en_s, wd_expired_s;

  assign in_hs_s   = in_tready_q & in_tvalid;
  assign exp_hs_s  = exp_in_tvalid_q & exp_in_tready;
  assign exp_res_s = exp_out_tready_q & exp_out_tvalid;
  assign mul_hs_s  = mul_in_tvalid_q & mul_in_tready;
  assign mul_res_s = mul_out_tready_q & mul_out_tvalid;
  assign out_hs_s  = out_tvalid_q & out_tready;
  assign p_small_s = (p_q < TWO);

  // The watchdog restarts whenever a WAIT state is entered and runs only
  // while the controller sits in a WAIT state.
  assign wd_load_s = is_wait(state_d) && (state_d != state_q);
  assign wd_en_s   = is_wait(state_q);

  op_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .load_i    (wd_load_s),
    .load_val_i(WD_LOAD),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a datapath result beats a same-cycle watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) state_d = ST_EXP1_REQ;
        else         state_d = ST_IDLE;
      end
      ST_EXP1_REQ: begin
        if (p_small_s)     state_d = ST_DONE;
        else if (exp_hs_s) state_d = ST_EXP1_WAIT;
        else               state_d = ST_EXP1_REQ;
      end
      ST_EXP1_WAIT: begin
        if (exp_res_s)         state_d = ST_EXP2_REQ;
        else if (wd_expired_s) state_d = ST_DONE;
        else                   state_d = ST_EXP1_WAIT;
      end
      ST_EXP2_REQ: begin
        if (exp_hs_s) state_d = ST_EXP2_WAIT;
        else          state_d = ST_EXP2_REQ;
      end
      ST_EXP2_WAIT: begin
        if (exp_res_s)         state_d = ST_MUL_REQ;
        else if (wd_expired_s) state_d = ST_DONE;
        else                   state_d = ST_EXP2_WAIT;
      end
      ST_MUL_REQ: begin
        if (mul_hs_s) state_d = ST_MUL_WAIT;
        else          state_d = ST_MUL_REQ;
      end
      ST_MUL_WAIT: begin
        if (mul_res_s)         state_d = ST_DONE;
        else if (wd_expired_s) state_d = ST_DONE;
        else                   state_d = ST_MUL_WAIT;
      end
      ST_DONE: begin
        if (out_hs_s) state_d = ST_IDLE;
        else          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, result capture and error/abort handling.
  always_comb begin
    g_d = g_q; y_d = y_q; k_d = k_q; m_d = m_q; p_d = p_q;
    s_d = s_q; c1_d = c1_q; c2_d = c2_q; err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) begin
          g_d = in_g; y_d = in_y; k_d = in_k; m_d = in_m; p_d = in_p;
          s_d = ZERO; c1_d = ZERO; c2_d = ZERO; err_d = 1'b0;
        end else begin
          g_d = g_q;
        end
      end
      ST_EXP1_REQ: begin
        if (p_small_s) begin
          c1_d = ZERO; c2_d = ZERO; err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_EXP1_WAIT: begin
        if (exp_res_s) begin
          c1_d = exp_out_tdata;
        end else if (wd_expired_s) begin
          c1_d = ZERO; c2_d = ZERO; err_d = 1'b1;
        end else begin
          c1_d = c1_q;
        end
      end
      ST_EXP2_WAIT: begin
        if (exp_res_s) begin
          s_d = exp_out_tdata;
        end else if (wd_expired_s) begin
          c1_d = ZERO; c2_d = ZERO; err_d = 1'b1;
        end else begin
          s_d = s_q;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_res_s) begin
          c2_d = mul_out_tdata; err_d = 1'b0;
        end else if (wd_expired_s) begin
          c1_d = ZERO; c2_d = ZERO; err_d = 1'b1;
        end else begin
          c2_d = c2_q;
        end
      end
      default: begin
        s_d = s_q;
      end
    endcase
  end

  // Output decode from the next state so every handshake output is a flop.
  always_comb begin
    p_small_d        = (p_d < TWO);
    in_tready_d      = (state_d == ST_IDLE);
    busy_d           = (state_d != ST_IDLE);
    exp_in_tvalid_d  = ((state_d == ST_EXP1_REQ) && !p_small_d) || (state_d == ST_EXP2_REQ);
    exp_out_tready_d = (state_d == ST_EXP1_WAIT) || (state_d == ST_EXP2_WAIT);
    mul_in_tvalid_d  = (state_d == ST_MUL_REQ);
    mul_out_tready_d = (state_d == ST_MUL_WAIT);
    out_tvalid_d     = (state_d == ST_DONE);
  end

  // Operand, result and handshake-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q <= ZERO; y_q <= ZERO; k_q <= ZERO; m_q <= ZERO; p_q <= ZERO;
      s_q <= ZERO; c1_q <= ZERO; c2_q <= ZERO; err_q <= 1'b0;
      in_tready_q      <= 1'b0;
      busy_q           <= 1'b0;
      exp_in_tvalid_q  <= 1'b0;
      exp_out_tready_q <= 1'b0;
      mul_in_tvalid_q  <= 1'b0;
      mul_out_tready_q <= 1'b0;
      out_tvalid_q     <= 1'b0;
    end else begin
      g_q <= g_d; y_q <= y_d; k_q <= k_d; m_q <= m_d; p_q <= p_d;
      s_q <= s_d; c1_q <= c1_d; c2_q <= c2_d; err_q <= err_d;
      in_tready_q      <= in_tready_d;
      busy_q           <= busy_d;
      exp_in_tvalid_q  <= exp_in_tvalid_d;
      exp_out_tready_q <= exp_out_tready_d;
      mul_in_tvalid_q  <= mul_in_tvalid_d;
      mul_out_tready_q <= mul_out_tready_d;
      out_tvalid_q     <= out_tvalid_d;
    end
  end

  assign in_tready         = in_tready_q;
  assign busy              = busy_q;
  assign exp_base_tdata    = (state_q == ST_EXP2_REQ) ? y_q : g_q;
  assign exp_power_tdata   = k_q;
  assign exp_modulus_tdata = p_q;
  assign exp_in_tvalid     = exp_in_tvalid_q;
  assign exp_out_tready    = exp_out_tready_q;
  assign mul_a_tdata       = m_q;
  assign mul_b_tdata       = s_q;
  assign mul_mod_tdata     = p_q;
  assign mul_in_tvalid     = mul_in_tvalid_q;
  assign mul_out_tready    = mul_out_tready_q;
  assign c1_tdata          = c1_q;
  assign c2_tdata          = c2_q;
  assign out_err           = err_q;
  assign out_tvalid        = out_tvalid_q;

endmodule

// File: tb/tb_elgamal_enc_seq.sv
module tb_elgamal_enc_seq;

  localparam int SIZE   = 32;
  localparam int TMO    = 64;
  localparam int BUDGET = 1000;

  typedef struct {
    logic [SIZE-1:0] c1;
    logic [SIZE-1:0] c2;
    logic            err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic [SIZE-1:0] in_g, in_y, in_k, in_m, in_p;
  logic in_tvalid, in_tready;
  logic [SIZE-1:0] exp_base_tdata, exp_power_tdata, exp_modulus_tdata, exp_out_tdata;
  logic exp_in_tvalid, exp_in_tready, exp_out_tvalid, exp_out_tready;
  logic [SIZE-1:0] mul_a_tdata, mul_b_tdata, mul_mod_tdata, mul_out_tdata;
  logic mul_in_tvalid, mul_in_tready, mul_out_tvalid, mul_out_tready;
  logic [SIZE-1:0] c1_tdata, c2_tdata;
  logic out_err, out_tvalid, out_tready, busy;

  int nchecks = 0;
  int nerrors = 0;

  // stimulus knobs
  bit exp_hang = 1'b0;
  bit exp_stall = 1'b0;
  bit spurious = 1'b0;
  int lat_max = 3;

  // scoreboard state
  res_t expq[$];
  bit   outstanding = 1'b0;
  bit   settle = 1'b0;
  int   nout = 0;
  int   exp_tv_cnt = 0;
  int   exp_hs_cnt = 0;
  logic [SIZE-1:0] last_c1, last_c2;
  logic last_err;

  always #5 clk = ~clk;

  elgamal_enc_seq #(.SIZE(SIZE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_g(in_g), .in_y(in_y), .in_k(in_k), .in_m(in_m), .in_p(in_p),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .exp_base_tdata(exp_base_tdata), .exp_power_tdata(exp_power_tdata),
    .exp_modulus_tdata(exp_modulus_tdata), .exp_in_tvalid(exp_in_tvalid),
    .exp_in_tready(exp_in_tready), .exp_out_tdata(exp_out_tdata),
    .exp_out_tvalid(exp_out_tvalid), .exp_out_tready(exp_out_tready),
    .mul_a_tdata(mul_a_tdata), .mul_b_tdata(mul_b_tdata), .mul_mod_tdata(mul_mod_tdata),
    .mul_in_tvalid(mul_in_tvalid), .mul_in_tready(mul_in_tready),
    .mul_out_tdata(mul_out_tdata), .mul_out_tvalid(mul_out_tvalid),
    .mul_out_tready(mul_out_tready),
    .c1_tdata(c1_tdata), .c2_tdata(c2_tdata), .out_err(out_err),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    nchecks++;
    if (act !== exp_v) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // plain square-and-multiply on 64-bit integers
  function automatic logic [SIZE-1:0] f_modexp(input logic [SIZE-1:0] b, input logic [SIZE-1:0] e,
                                               input logic [SIZE-1:0] m);
    longint unsigned r, x, mm;
    if (m < 2) return '0;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < SIZE; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[SIZE-1:0];
  endfunction

  function automatic logic [SIZE-1:0] f_mulmod(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                               input logic [SIZE-1:0] m);
    longint unsigned r;
    if (m < 2) return '0;
    r = (64'(a) * 64'(b)) % 64'(m);
    return r[SIZE-1:0];
  endfunction

  function automatic res_t model(input logic [SIZE-1:0] g, input logic [SIZE-1:0] y,
                                 input logic [SIZE-1:0] k, input logic [SIZE-1:0] m,
                                 input logic [SIZE-1:0] p, input bit hang);
    res_t r;
    if (p < 2 || hang) begin
      r.c1 = '0; r.c2 = '0; r.err = 1'b1;
    end else begin
      r.c1 = f_modexp(g, k, p);
      r.c2 = f_mulmod(m, f_modexp(y, k, p), p);
      r.err = 1'b0;
    end
    return r;
  endfunction

  // mod_exp responder: random latency, optional input stalls, hang mode,
  // and stray result pulses while no request is pending
  initial begin : exp_resp
    bit act, ihs, ohs;
    int lat;
    logic [SIZE-1:0] b, e, m, res;
    act = 0; ihs = 0; ohs = 0; lat = 0; res = '0;
    exp_in_tready = 1'b0; exp_out_tvalid = 1'b0; exp_out_tdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0; ihs = 0; ohs = 0;
        exp_in_tready = 1'b0; exp_out_tvalid = 1'b0;
      end else begin
        if (ohs) act = 0;
        if (ihs) begin
          act = !exp_hang;
          lat = $urandom_range(0, lat_max);
          res = f_modexp(b, e, m);
        end
        if (act) begin
          if (lat == 0) begin exp_out_tvalid = 1'b1; exp_out_tdata = res; end
          else begin lat--; exp_out_tvalid = 1'b0; end
        end else if (spurious && !exp_hang && $urandom_range(0, 7) == 0) begin
          exp_out_tvalid = 1'b1; exp_out_tdata = $urandom;
        end else begin
          exp_out_tvalid = 1'b0;
        end
        exp_in_tready = !act && !(exp_stall && $urandom_range(0, 2) == 0);
        ihs = exp_in_tvalid && exp_in_tready;
        if (ihs) begin
          b = exp_base_tdata; e = exp_power_tdata; m = exp_modulus_tdata;
          exp_hs_cnt++;
        end
        ohs = exp_out_tvalid && exp_out_tready;
      end
    end
  end

  // modular multiplier responder
  initial begin : mul_resp
    bit act, ihs, ohs;
    int lat;
    logic [SIZE-1:0] a, b, m, res;
    act = 0; ihs = 0; ohs = 0; lat = 0; res = '0;
    mul_in_tready = 1'b0; mul_out_tvalid = 1'b0; mul_out_tdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0; ihs = 0; ohs = 0;
        mul_in_tready = 1'b0; mul_out_tvalid = 1'b0;
      end else begin
        if (ohs) act = 0;
        if (ihs) begin
          act = 1;
          lat = $urandom_range(0, lat_max);
          res = f_mulmod(a, b, m);
        end
        if (act && lat == 0) begin mul_out_tvalid = 1'b1; mul_out_tdata = res; end
        else begin
          if (act) lat--;
          mul_out_tvalid = 1'b0;
        end
        mul_in_tready = !act && ($urandom_range(0, 3) != 0);
        ihs = mul_in_tvalid && mul_in_tready;
        if (ihs) begin a = mul_a_tdata; b = mul_b_tdata; m = mul_mod_tdata; end
        ohs = mul_out_tvalid && mul_out_tready;
      end
    end
  end

  // scoreboard: compare every cycle the outputs are meaningful
  initial begin : compare
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        outstanding = 0; expq.delete(); settle = 1;
      end else begin
        if (exp_in_tvalid) exp_tv_cnt++;
        if (settle) settle = 0;
        else begin
          chk("in_tready", in_tready, !outstanding);
          chk("busy", busy, outstanding);
        end
        if (out_tvalid) begin
          if (expq.size() == 0) chk("unexpected_out_tvalid", out_tvalid, 1'b0);
          else begin
            chk("c1", c1_tdata, expq[0].c1);
            chk("c2", c2_tdata, expq[0].c2);
            chk("out_err", out_err, expq[0].err);
            if (out_tready) begin
              last_c1 = c1_tdata; last_c2 = c2_tdata; last_err = out_err;
              void'(expq.pop_front());
              outstanding = 0;
              nout++;
            end
          end
        end
        if (in_tvalid && in_tready) begin
          expq.push_back(model(in_g, in_y, in_k, in_m, in_p, exp_hang));
          outstanding = 1;
        end
      end
    end
  end

  task automatic send(input logic [SIZE-1:0] g, input logic [SIZE-1:0] y, input logic [SIZE-1:0] k,
                      input logic [SIZE-1:0] m, input logic [SIZE-1:0] p);
    int t;
    t = 0;
    @(negedge clk);
    in_g = g; in_y = y; in_k = k; in_m = m; in_p = p; in_tvalid = 1'b1;
    while (!in_tready && t < BUDGET) begin @(negedge clk); t++; end
    if (t >= BUDGET) chk("accept_timeout", in_tready, 1'b1);
    @(negedge clk);
    in_tvalid = 1'b0;
    in_g = $urandom; in_y = $urandom; in_k = $urandom; in_m = $urandom; in_p = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (outstanding && t < BUDGET);
    if (outstanding) chk("complete_timeout", outstanding, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_tvalid"}, out_tvalid, 1'b0);
    chk({tag, "_in_tready"}, in_tready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_exp_in_tvalid"}, exp_in_tvalid, 1'b0);
    chk({tag, "_exp_out_tready"}, exp_out_tready, 1'b0);
    chk({tag, "_mul_in_tvalid"}, mul_in_tvalid, 1'b0);
    chk({tag, "_mul_out_tready"}, mul_out_tready, 1'b0);
    chk({tag, "_c1"}, c1_tdata, '0);
    chk({tag, "_c2"}, c2_tdata, '0);
    chk({tag, "_out_err"}, out_err, 1'b0);
  endtask

  initial begin : main
    int t, n, n0, base;
    res_t r;
    logic [SIZE-1:0] p;
    rst = 1'b1; in_tvalid = 1'b0; out_tready = 1'b1;
    in_g = '0; in_y = '0; in_k = '0; in_m = '0; in_p = '0;

    // hand-computed anchors for the model: 5^6=8, 8^6=13, 10*13=15 (mod 23)
    r = model(32'd5, 32'd8, 32'd6, 32'd10, 32'd23, 1'b0);
    chk("model_c1", r.c1, 32'd8);
    chk("model_c2", r.c2, 32'd15);
    chk("model_s", f_modexp(32'd8, 32'd6, 32'd23), 32'd13);

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #2 rst = 1'b0;

    // reference vector
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd23);
    wait_idle();
    chk("ref_c1", last_c1, 32'd8);
    chk("ref_c2", last_c2, 32'd15);
    chk("ref_err", last_err, 1'b0);

    // degenerate modulus: no mod_exp request may be issued
    base = exp_tv_cnt;
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd1);
    wait_idle();
    chk("p1_c1", last_c1, 32'd0);
    chk("p1_c2", last_c2, 32'd0);
    chk("p1_err", last_err, 1'b1);
    chk("p1_no_exp_req", exp_tv_cnt - base, 0);

    // output back-pressure: result held for 5 cycles, one transfer
    out_tready = 1'b0;
    n0 = nout;
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd23);
    t = 0;
    while (!out_tvalid && t < BUDGET) begin @(negedge clk); t++; end
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_out_tvalid", out_tvalid, 1'b1);
      chk("hold_c1", c1_tdata, 32'd8);
    end
    out_tready = 1'b1;
    wait_idle();
    chk("hold_single_transfer", nout - n0, 1);
    chk("hold_c2", last_c2, 32'd15);

    // mod_exp never answers: DONE exactly TMO cycles after EXP1_WAIT entry
    exp_hang = 1'b1;
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd23);
    #1;
    t = 0;
    while (!(exp_in_tvalid && exp_in_tready) && t < 100) begin @(negedge clk); #1; t++; end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!out_tvalid && n < TMO + 20);
    // n counts the WAIT-entry edge too, hence TMO+1 negedges
    chk("timeout_latency", n, TMO + 1);
    wait_idle();
    exp_hang = 1'b0;
    chk("timeout_err", last_err, 1'b1);
    chk("timeout_c1", last_c1, 32'd0);

    // reset during EXP2_WAIT, then the reference vector again
    base = exp_hs_cnt;
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd23);
    t = 0;
    while (!(exp_out_tready && exp_hs_cnt == base + 2) && t < BUDGET) begin @(negedge clk); #1; t++; end
    chk("reached_exp2_wait", exp_out_tready, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd23);
    wait_idle();
    chk("post_rst_c1", last_c1, 32'd8);
    chk("post_rst_c2", last_c2, 32'd15);

    // back-to-back requests with mod_exp input stalls
    exp_stall = 1'b1;
    n0 = nout;
    send(32'd5, 32'd8, 32'd6, 32'd10, 32'd23);
    send(32'd3, 32'd9, 32'd7, 32'd4, 32'd101);
    wait_idle();
    chk("b2b_count", nout - n0, 2);
    chk("b2b_c2", last_c2, 32'(f_mulmod(32'd4, f_modexp(32'd9, 32'd7, 32'd101), 32'd101)));

    // randomized traffic with stray mod_exp results
    spurious = 1'b1;
    for (int i = 0; i < 25; i++) begin
      exp_stall = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) p = 32'($urandom_range(0, 1));
      else p = $urandom | 32'h2;
      send($urandom, $urandom, $urandom, $urandom, p);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
